am_chan_sequencer: RTL and testbench

Stress-test channel sequencer for the 12-channel AM broadcast datapath. It sits between the control register block's `channel_enable`/`master_enable` outputs and the per-channel NCO/modulator enables. It turns a static allow-mask into a timed enable pattern:

- static: all allowed channels on at once;
- ramp-up: allowed channels added one at a time;
- round-robin: exactly one allowed channel on, rotating.

Each step lasts a programmable dwell, counted in `clk` cycles (125 MHz).

---
 rtl/am_radio_pkg.sv | 20 ++
 rtl/am_next_chan.sv | 33 +++
 rtl/am_chan_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_am_chan_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_radio_pkg.sv
// Shared definitions for the AM broadcast channel control path.
package am_radio_pkg;

  localparam int unsigned NUM_CHANNELS = 12;
  localparam int unsigned IDX_W        = 4;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_RAMP   = 2'd1,
    MODE_ROUND  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/am_next_chan.sv
// Wrap-around priority encoder: next set bit of mask strictly above cur_idx_i,
// else the lowest set bit. found_higher_o tells whether the wrap was avoided.
module am_next_chan #(
  parameter int unsigned NUM_CHANNELS = 12,
  parameter int unsigned IDX_W        = 4
) (
  input  logic [NUM_CHANNELS-1:0] mask_i,
  input  logic [IDX_W-1:0]        cur_idx_i,
  output logic [IDX_W-1:0]        next_idx_o,
  output logic                    found_higher_o
);

  logic [IDX_W-1:0] lowest_idx;
  logic [IDX_W-1:0] higher_idx;

  // Scan downward so the last hit is the lowest qualifying index.
  always_comb begin
    lowest_idx     = '0;
    higher_idx     = '0;
    found_higher_o = 1'b0;
    for (int i = int'(NUM_CHANNELS) - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        lowest_idx = IDX_W'(i);
        if (i > int'(cur_idx_i)) begin
          higher_idx     = IDX_W'(i);
          found_higher_o = 1'b1;
        end
      end
    end
    next_idx_o = found_higher_o ? higher_idx : lowest_idx;
  end

endmodule

// File: rtl/am_chan_sequencer.sv
// Stress-test channel sequencer: turns a static allow-mask into a timed
// enable pattern (static / ramp-up / round-robin) with programmable dwell.
module am_chan_sequencer #(
  parameter int unsigned NUM_CHANNELS = am_radio_pkg::NUM_CHANNELS,
  parameter int unsigned DWELL_W      = 32
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic                              stop,
  input  logic                              master_enable,
  input  logic [1:0]                        mode,
  input  logic [NUM_CHANNELS-1:0]           ch_allow,
  input  logic [DWELL_W-1:0]                dwell,
  output logic [NUM_CHANNELS-1:0]           ch_enable_out,
  output logic [am_radio_pkg::IDX_W-1:0]    active_idx,
  output logic                              step,
  output logic                              busy,
  output logic                              full,
  output logic                              done
);

  import am_radio_pkg::*;

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [NUM_CHANNELS-1:0] allow_q, allow_d;
  logic [DWELL_W-1:0]      reload_q, reload_d;
  logic [DWELL_W-1:0]      cnt_q, cnt_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    step_q, step_d;
  logic                    busy_q, busy_d;
  logic                    full_q, full_d;
  logic                    done_q, done_d;

  logic [IDX_W-1:0]        next_idx;
  logic                    found_higher;
  logic [NUM_CHANNELS-1:0] next_oh;
  logic [NUM_CHANNELS-1:0] ramp_mask;
  logic [IDX_W-1:0]        start_low_idx;
  logic [IDX_W-1:0]        start_high_idx;
  logic                    seen;
  logic [DWELL_W-1:0]      dwell_reload;
  logic                    stop_req;
  logic                    start_ok;
  mode_e                   mode_in;

  am_next_chan #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .IDX_W        (IDX_W)
  ) u_next_chan (
    .mask_i         (allow_q),
    .cur_idx_i      (idx_q),
    .next_idx_o     (next_idx),
    .found_higher_o (found_higher)
  );

  // Lowest/highest allowed index of the live input mask, used on start.
  always_comb begin
    start_low_idx  = '0;
    start_high_idx = '0;
    seen           = 1'b0;
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      if (ch_allow[i]) begin
        start_high_idx = IDX_W'(i);
        if (!seen) begin
          start_low_idx = IDX_W'(i);
        end
        seen = 1'b1;
      end
    end
  end

  assign next_oh      = NUM_CHANNELS'(1) << next_idx;
  assign ramp_mask    = mask_q | next_oh;
  // Dwell of 0 behaves as 1, so the reload value is max(dwell,1)-1.
  assign dwell_reload = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign stop_req     = stop || !master_enable;
  assign start_ok     = start && !stop && master_enable && (ch_allow != '0);
  assign mode_in      = mode_e'(mode);

  // Next-state for FSM, dwell counter and registered outputs.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    allow_d  = allow_q;
    reload_d = reload_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    idx_d    = idx_q;
    step_d   = 1'b0;
    busy_d   = busy_q;
    full_d   = full_q;
    done_d   = 1'b0;

    if (state_q != ST_IDLE && stop_req) begin
      // Stop beats any dwell expiry happening in the same cycle.
      state_d = ST_IDLE;
      cnt_d   = '0;
      mask_d  = '0;
      idx_d   = '0;
      busy_d  = 1'b0;
      full_d  = 1'b0;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            mode_d   = mode_in;
            allow_d  = ch_allow;
            reload_d = dwell_reload;
            cnt_d    = dwell_reload;
            step_d   = 1'b1;
            busy_d   = 1'b1;
            if (mode_in == MODE_RAMP || mode_in == MODE_ROUND) begin
              state_d = ST_RUN;
              mask_d  = NUM_CHANNELS'(1) << start_low_idx;
              idx_d   = start_low_idx;
            end else begin
              // STATIC and the reserved encoding light everything at once.
              state_d = ST_HOLD;
              mask_d  = ch_allow;
              idx_d   = start_high_idx;
              full_d  = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else begin
            cnt_d = reload_q;
            if (mode_q == MODE_ROUND) begin
              mask_d = next_oh;
              idx_d  = next_idx;
              step_d = 1'b1;
            end else if (found_higher) begin
              mask_d = ramp_mask;
              idx_d  = next_idx;
              step_d = 1'b1;
              // Ramp fills upward in order, so a complete mask means no higher channel.
              if (ramp_mask == allow_q) begin
                state_d = ST_HOLD;
                full_d  = 1'b1;
              end
            end else begin
              state_d = ST_HOLD;
              full_d  = 1'b1;
            end
          end
        end
        ST_HOLD: begin
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_STATIC;
      allow_q  <= '0;
      reload_q <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      idx_q    <= '0;
      step_q   <= 1'b0;
      busy_q   <= 1'b0;
      full_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      allow_q  <= allow_d;
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      full_q   <= full_d;
      done_q   <= done_d;
    end
  end

  assign ch_enable_out = mask_q;
  assign active_idx    = idx_q;
  assign step          = step_q;
  assign busy          = busy_q;
  assign full          = full_q;
  assign done          = done_q;

endmodule

// File: tb/tb_am_chan_sequencer.sv
// Directed bench for am_chan_sequencer with a per-cycle expectation queue.
module tb_am_chan_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        master_enable = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [11:0] ch_allow = '0;
  logic [31:0] dwell = '0;
  logic [11:0] ch_enable_out;
  logic [3:0]  active_idx;
  logic        step;
  logic        busy;
  logic        full;
  logic        done;

  am_chan_sequencer #(
    .NUM_CHANNELS (12),
    .DWELL_W      (32)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .stop          (stop),
    .master_enable (master_enable),
    .mode          (mode),
    .ch_allow      (ch_allow),
    .dwell         (dwell),
    .ch_enable_out (ch_enable_out),
    .active_idx    (active_idx),
    .step          (step),
    .busy          (busy),
    .full          (full),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] mask;
    logic [3:0]  idx;
    logic        stp;
    logic        bsy;
    logic        ful;
    logic        dn;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic push(input logic [11:0] m, input logic [3:0] i, input logic s,
                      input logic b, input logic f, input logic d);
    exp_t e;
    e.mask = m;
    e.idx  = i;
    e.stp  = s;
    e.bsy  = b;
    e.ful  = f;
    e.dn   = d;
    sb.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) push(12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input string fld, input logic [31:0] got,
                     input logic [31:0] expv);
    n_checks++;
    assert (got === expv) n_pass = n_pass + 1;
    else $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, got, expv);
  endtask

  // Advance one edge, then compare all outputs against the head of the queue.
  task automatic tick_chk(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, "mask", 32'(ch_enable_out), 32'(e.mask));
      chk(tag, "idx", 32'(active_idx), 32'(e.idx));
      chk(tag, "step", 32'(step), 32'(e.stp));
      chk(tag, "busy", 32'(busy), 32'(e.bsy));
      chk(tag, "full", 32'(full), 32'(e.ful));
      chk(tag, "done", 32'(done), 32'(e.dn));
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) tick_chk(tag);
  endtask

  // RAMP over allow=0x00F with dwell=4, for edges 1..n after the start edge.
  task automatic push_ramp4(input int n);
    int          k;
    logic [11:0] m;
    for (int c = 1; c <= n; c++) begin
      k = (c - 1) / 4;
      if (k > 3) k = 3;
      m = (12'h001 << (k + 1)) - 12'h001;
      push(m, 4'(k), ((c - 1) % 4 == 0) && (c <= 13), 1'b1, c >= 13, 1'b0);
    end
  endtask

  // Stop pulse: done one cycle later, then quiet idle.
  task automatic stop_seq(input string tag);
    push(12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_idle(1);
    stop = 1'b1;
    tick_chk(tag);
    stop = 1'b0;
    tick_chk(tag);
  endtask

  logic [3:0] rr_idx [5];

  initial begin
    rr_idx[0] = 4'd0;
    rr_idx[1] = 4'd2;
    rr_idx[2] = 4'd8;
    rr_idx[3] = 4'd11;
    rr_idx[4] = 4'd0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    push_idle(1);
    tick_chk("reset");
    rstn = 1'b1;
    push_idle(1);
    tick_chk("post_reset");

    // RAMP, dwell 4, allow 0x00F; config changes after start must be ignored
    mode = 2'd1; ch_allow = 12'h00F; dwell = 32'd4;
    push_ramp4(16);
    start = 1'b1;
    tick_chk("ramp");
    start = 1'b0;
    mode = 2'd2; ch_allow = 12'h800; dwell = 32'd1;
    run("ramp", 15);
    stop_seq("ramp_stop");

    // ROUND, dwell 2, allow 0x905, through the wrap
    mode = 2'd2; ch_allow = 12'h905; dwell = 32'd2;
    for (int c = 1; c <= 10; c++)
      push(12'h001 << rr_idx[(c - 1) / 2], rr_idx[(c - 1) / 2], (c - 1) % 2 == 0,
           1'b1, 1'b0, 1'b0);
    start = 1'b1;
    tick_chk("round");
    start = 1'b0;
    ch_allow = 12'h0F0; mode = 2'd0;
    run("round", 9);
    stop_seq("round_stop");

    // ROUND stop driven after edge 6, colliding with the dwell expiry at edge 7
    mode = 2'd2; ch_allow = 12'h905; dwell = 32'd2;
    for (int c = 1; c <= 6; c++)
      push(12'h001 << rr_idx[(c - 1) / 2], rr_idx[(c - 1) / 2], (c - 1) % 2 == 0,
           1'b1, 1'b0, 1'b0);
    start = 1'b1;
    tick_chk("round2");
    start = 1'b0;
    run("round2", 5);
    stop_seq("round2_stop");

    // STATIC, allow 0xFFF, mask holds 100 cycles
    mode = 2'd0; ch_allow = 12'hFFF; dwell = 32'd3;
    push(12'hFFF, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 100; c++) push(12'hFFF, 4'd11, 1'b0, 1'b1, 1'b1, 1'b0);
    start = 1'b1;
    tick_chk("static");
    start = 1'b0;
    run("static_hold", 100);
    stop_seq("static_stop");

    // Reserved mode behaves as STATIC
    mode = 2'd3; ch_allow = 12'h0A0; dwell = 32'd1;
    push(12'h0A0, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) push(12'h0A0, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0);
    start = 1'b1;
    tick_chk("rsvd");
    start = 1'b0;
    run("rsvd", 3);
    stop_seq("rsvd_stop");

    // master_enable drop during RAMP acts as stop
    mode = 2'd1; ch_allow = 12'h00F; dwell = 32'd4;
    push_ramp4(6);
    start = 1'b1;
    tick_chk("me_drop");
    start = 1'b0;
    run("me_drop", 5);
    push(12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_idle(1);
    master_enable = 1'b0;
    tick_chk("me_drop_stop");
    master_enable = 1'b1;
    tick_chk("me_drop_stop");

    // dwell 0 treated as 1
    mode = 2'd1; ch_allow = 12'h003; dwell = 32'd0;
    push(12'h001, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(12'h003, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    push(12'h003, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    start = 1'b1;
    tick_chk("dwell0");
    start = 1'b0;
    run("dwell0", 2);
    stop_seq("dwell0_stop");

    // Single-channel RAMP: HOLD after first dwell without an extra step
    mode = 2'd1; ch_allow = 12'h010; dwell = 32'd3;
    push(12'h010, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    push(12'h010, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    push(12'h010, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    push(12'h010, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    push(12'h010, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    start = 1'b1;
    tick_chk("ramp1");
    start = 1'b0;
    run("ramp1", 4);
    stop_seq("ramp1_stop");

    // Single-channel ROUND: mask constant, step each dwell
    mode = 2'd2; ch_allow = 12'h040; dwell = 32'd2;
    for (int c = 1; c <= 5; c++) push(12'h040, 4'd6, (c % 2) == 1, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    tick_chk("round1");
    start = 1'b0;
    run("round1", 4);
    stop_seq("round1_stop");

    // Ignored starts: empty mask, master disabled, start with stop
    mode = 2'd1; ch_allow = 12'h000; dwell = 32'd4;
    push_idle(2);
    start = 1'b1;
    tick_chk("start_empty");
    start = 1'b0;
    tick_chk("start_empty");
    ch_allow = 12'h00F; master_enable = 1'b0;
    push_idle(2);
    start = 1'b1;
    tick_chk("start_me0");
    start = 1'b0; master_enable = 1'b1;
    tick_chk("start_me0");
    push_idle(2);
    start = 1'b1; stop = 1'b1;
    tick_chk("start_stop");
    start = 1'b0; stop = 1'b0;
    tick_chk("start_stop");

    // Reset mid-run: zeros, no done, then a clean RAMP
    push_ramp4(6);
    start = 1'b1;
    tick_chk("rst_mid");
    start = 1'b0;
    run("rst_mid", 5);
    push_idle(2);
    rstn = 1'b0;
    tick_chk("rst_mid_reset");
    rstn = 1'b1;
    tick_chk("rst_mid_after");
    push_ramp4(14);
    start = 1'b1;
    tick_chk("ramp_again");
    start = 1'b0;
    run("ramp_again", 13);
    stop_seq("ramp_again_stop");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
